// File: rtl/wb_stage.sv
// wb_stage: write-back stage with register-file write port, busy scoreboard and optional bypass (WB_BYPASS_EN)
module wb_stage #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_WB,
    input  logic [1:0]       WBsrc,
    input  logic             RegWrEn,
    input  logic             regDst,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] ALUout,
    input  logic [WIDTH-1:0] MemOut,
    input  logic [WIDTH-1:0] nextPC,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             regWr,
    output logic [AW-1:0]    RW,
    output logic [WIDTH-1:0] BusW,
    output logic [NREG-1:0]  busy,
    output logic             wb_done,
    output logic             wb_overrun,
    output logic             fwd_valid,
    output logic [AW-1:0]    fwd_rd,
    output logic [WIDTH-1:0] fwd_data
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t           state_q, state_d;
    logic             reg_wr_q, reg_wr_d;
    logic [AW-1:0]    rw_q, rw_d;
    logic [WIDTH-1:0] bus_w_q, bus_w_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [AW-1:0]    dest_sel;
    logic [WIDTH-1:0] data_sel;
    logic             wr_ok_sel;

    // Decode the destination, write-back value and write permission of the incoming instruction
    always_comb begin
        dest_sel  = regDst ? {AW{1'b1}} : rd;
        data_sel  = WBsrc == 2'b00 ? ALUout : WBsrc == 2'b01 ? MemOut : nextPC;
        wr_ok_sel = RegWrEn && WBsrc != 2'b11 && dest_sel != '0;
    end

    // Next state and registered outputs; RW/BusW hold once latched, only regWr gates the write
    always_comb begin
        state_d   = state_q;
        reg_wr_d  = 1'b0;
        rw_d      = rw_q;
        bus_w_d   = bus_w_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (enable_WB && state_q != IDLE);
        busy_d    = busy_q;
        case (state_q)
            IDLE: if (enable_WB) begin
                state_d  = WRITE;
                reg_wr_d = wr_ok_sel;
                rw_d     = dest_sel;
                bus_w_d  = data_sel;
            end
            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                state_d        = IDLE;
                busy_d[rw_q]   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            reg_wr_q  <= 1'b0;
            rw_q      <= '0;
            bus_w_q   <= '0;
            busy_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_wr_q  <= reg_wr_d;
            rw_q      <= rw_d;
            bus_w_q   <= bus_w_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign regWr      = reg_wr_q;
    assign RW         = rw_q;
    assign BusW       = bus_w_q;
    assign busy       = busy_q;
    assign wb_done    = done_q;
    assign wb_overrun = overrun_q;

`ifdef WB_BYPASS_EN
    assign fwd_valid = reg_wr_q;
    assign fwd_rd    = state_q == WRITE ? rw_q : '0;
    assign fwd_data  = state_q == WRITE ? bus_w_q : '0;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with a write scoreboard and immediate assertions
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_WB = 1'b0;
    logic [1:0]  WBsrc = 2'b00;
    logic        RegWrEn = 1'b0;
    logic        regDst = 1'b0;
    logic [2:0]  rd = 3'd0;
    logic [15:0] ALUout = 16'h0, MemOut = 16'h0, nextPC = 16'h0;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_rd = 3'd0;
    logic        regWr, wb_done, wb_overrun, fwd_valid;
    logic [2:0]  RW, fwd_rd;
    logic [15:0] BusW, fwd_data;
    logic [7:0]  busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [18:0] sb[$];
    logic        exp_ovr = 1'b0;

    wb_stage dut (
        .clk(clk), .reset(reset), .enable_WB(enable_WB), .WBsrc(WBsrc), .RegWrEn(RegWrEn),
        .regDst(regDst), .rd(rd), .ALUout(ALUout), .MemOut(MemOut), .nextPC(nextPC),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .regWr(regWr), .RW(RW), .BusW(BusW),
        .busy(busy), .wb_done(wb_done), .wb_overrun(wb_overrun), .fwd_valid(fwd_valid),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] r);
        issue_valid = 1'b1;
        issue_rd = r;
        tick();
        issue_valid = 1'b0;
    endtask

    // Launch one write-back and check the WRITE cycle against the scoreboard
    task automatic start_op(input logic [1:0] src, input logic we, input logic dst,
                            input logic [2:0] r, input logic [15:0] a, m, p);
        logic [2:0]  d;
        logic [15:0] v;
        logic        w;
        logic [18:0] e;
        d = dst ? 3'd7 : r;
        v = src == 2'd0 ? a : src == 2'd1 ? m : p;
        w = we && src != 2'd3 && d != 3'd0;
        if (w) sb.push_back({d, v});
        WBsrc = src; RegWrEn = we; regDst = dst; rd = r; ALUout = a; MemOut = m; nextPC = p;
        enable_WB = 1'b1;
        tick();
        enable_WB = 1'b0;
        chk("write_en", regWr, w);
        chk("done_in_write", wb_done, 0);
        if (regWr) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("write_addr", RW, e[18:16]);
                chk("write_data", BusW, e[15:0]);
            end
        end
`ifdef WB_BYPASS_EN
        chk("fwd_valid", fwd_valid, w);
        if (w) begin
            chk("fwd_rd", fwd_rd, d);
            chk("fwd_data", fwd_data, v);
        end
`else
        chk("fwd_valid_off", fwd_valid, 0);
        chk("fwd_rd_off", fwd_rd, 0);
        chk("fwd_data_off", fwd_data, 0);
`endif
    endtask

    task automatic to_done();
        tick();
        chk("wr_one_cycle", regWr, 0);
        chk("done_pulse", wb_done, 1);
        chk("fwd_off_done", fwd_valid, 0);
    endtask

    task automatic to_idle();
        tick();
        chk("done_end", wb_done, 0);
        chk("overrun", wb_overrun, exp_ovr);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_regWr", regWr, 0);
        chk("rst_RW", RW, 0);
        chk("rst_BusW", BusW, 0);
        chk("rst_busy", busy, 8'h00);
        chk("rst_done", wb_done, 0);
        chk("rst_ovr", wb_overrun, 0);
        chk("rst_fwd", {fwd_valid, fwd_rd, fwd_data}, 0);

        issue(3'd5);
        chk("busy_set5", busy, 8'h20);
        start_op(2'd0, 1'b1, 1'b0, 3'd5, 16'hBEEF, 16'h0, 16'h0);
        to_done();
        chk("busy_in_done", busy, 8'h20);
        to_idle();
        chk("busy_clr5", busy, 8'h00);

        start_op(2'd2, 1'b1, 1'b1, 3'd2, 16'h0, 16'h0, 16'h0042);
        to_done();
        to_idle();

        start_op(2'd1, 1'b1, 1'b0, 3'd0, 16'h0, 16'hFFFF, 16'h0);
        to_done();
        to_idle();
        start_op(2'd3, 1'b1, 1'b0, 3'd4, 16'h4444, 16'h0, 16'h0);
        to_done();
        to_idle();
        start_op(2'd0, 1'b0, 1'b0, 3'd4, 16'h4444, 16'h0, 16'h0);
        to_done();
        to_idle();

        issue(3'd0);
        chk("issue_r0_ignored", busy, 8'h00);

        start_op(2'd0, 1'b1, 1'b0, 3'd6, 16'h00A5, 16'h0, 16'h0);
        to_done();
        to_idle();

        start_op(2'd0, 1'b1, 1'b0, 3'd1, 16'h1111, 16'h0, 16'h0);
        rd = 3'd2; ALUout = 16'h2222; enable_WB = 1'b1;
        to_done();
        enable_WB = 1'b0;
        exp_ovr = 1'b1;
        chk("ovr_set", wb_overrun, 1);
        chk("ovr_RW_kept", RW, 3'd1);
        chk("ovr_BusW_kept", BusW, 16'h1111);
        to_idle();
        chk("ovr_no_extra_write", regWr, 0);
        tick();
        chk("ovr_idle_quiet", {regWr, wb_done}, 0);
        chk("ovr_sticky", wb_overrun, 1);

        issue(3'd3);
        chk("busy_set3", busy, 8'h08);
        start_op(2'd0, 1'b1, 1'b0, 3'd3, 16'h3333, 16'h0, 16'h0);
        to_done();
        issue_valid = 1'b1; issue_rd = 3'd3;
        to_idle();
        issue_valid = 1'b0;
        chk("set_wins", busy, 8'h08);

        start_op(2'd0, 1'b1, 1'b0, 3'd3, 16'h1234, 16'h0, 16'h0);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_regWr", regWr, 0);
        chk("rst_async_busy", busy, 8'h00);
        chk("rst_async_ovr", wb_overrun, 0);
        exp_ovr = 1'b0;
        tick();
        reset = 1'b0;
        chk("rst_no_done", wb_done, 0);
        tick();
        chk("rst_no_done2", {regWr, wb_done}, 0);

        start_op(2'd0, 1'b1, 1'b0, 3'd2, 16'h5A5A, 16'h0, 16'h0);
        to_done();
        to_idle();
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the multi-cycle 16-bit RISC processor; the writing end of the register-file interface that the decode stage reads.
- Selects the write-back value and destination register, then drives regWr/RW/BusW into registerFile for exactly one cycle.
- Keeps an 8-bit busy scoreboard so decode can stall on registers with pending writes.
- Sequenced by the control unit via enable_WB.

Parameters:
- WIDTH, 16, datapath width of BusW, ALUout, MemOut, nextPC
- NREG, 8, number of architectural registers (sets busy width; RW is log2(NREG)=3 bits)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable_WB  input  1  one-cycle start pulse from control unit
- WBsrc  input  2  00 ALUout, 01 MemOut, 10 nextPC (return address), 11 no write
- RegWrEn  input  1  instruction writes a register
- regDst  input  1  0: destination rd, 1: destination R7 (call link)
- rd  input  3  destination field from decode
- ALUout  input  WIDTH  execute result
- MemOut  input  WIDTH  memory load data
- nextPC  input  WIDTH  PC+2 for link
- issue_valid  input  1  decode issued an instruction that will write issue_rd
- issue_rd  input  3  final destination of the issued instruction
- regWr  output  1  register-file write enable
- RW  output  3  register-file write address
- BusW  output  WIDTH  register-file write data
- busy  output  NREG  bit i set = write to Ri pending
- wb_done  output  1  one-cycle completion pulse to control unit
- wb_overrun  output  1  sticky error: enable_WB seen while not IDLE
- fwd_valid, fwd_rd[2:0], fwd_data[WIDTH-1:0]  output  bypass (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=IDLE; regWr=0, RW=0, BusW=0, busy=0, wb_done=0, wb_overrun=0, fwd_*=0.
- Three-state FSM: IDLE, WRITE, DONE. All outputs registered.
- IDLE: on enable_WB=1 at edge N, latch dest = regDst ? 3'b111 : rd, and data per WBsrc. Set wr_ok = RegWrEn && WBsrc!=11 && dest!=0. Go to WRITE.
- WRITE (cycle after edge N): regWr=wr_ok, RW=dest, BusW=data. Go to DONE at the next edge.
- DONE: regWr=0; wb_done=1 for one cycle; clear busy[dest]. Go to IDLE.
- Latency: enable_WB to regWr is 1 cycle, to wb_done is 2 cycles. Minimum spacing between starts is 3 cycles.
- R0 is hardwired zero: writes to it are suppressed (regWr stays 0), but the FSM still passes through DONE and pulses wb_done.
- WBsrc=11 or RegWrEn=0: no write, same FSM path.
- RW and BusW hold their last values after WRITE; only regWr gates the write.
- Scoreboard:
  - issue_valid sets busy[issue_rd] at the edge; issue_rd=0 is ignored.
  - Clear occurs in DONE.
  - Set and clear of the same bit in the same cycle: set wins.
- enable_WB in WRITE or DONE: ignored (latched values unchanged); wb_overrun set, sticky until reset.
- Reset mid-operation: FSM to IDLE, regWr drops asynchronously, busy cleared, no write completes.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: in WRITE, fwd_valid=wr_ok, fwd_rd=dest, fwd_data=data, so decode can forward instead of stalling. fwd_valid=0 in all other states.
- Undefined: fwd_valid, fwd_rd and fwd_data are tied to 0; no added logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset asserted mid-WRITE (dest R3, data 16'h1234) -> regWr=0 immediately, busy=8'h00, state IDLE, no wb_done pulse.
- issue_valid with issue_rd=5, then enable_WB with WBsrc=00, ALUout=16'hBEEF, rd=5, RegWrEn=1, regDst=0 -> busy=8'h20. One cycle later regWr=1, RW=5, BusW=16'hBEEF. The next cycle wb_done=1, and busy=8'h00 after that edge.
- Call link: WBsrc=10, nextPC=16'h0042, regDst=1, rd=2 -> RW=7, BusW=16'h0042, regWr=1 for exactly one cycle.
- Writes that must not occur: rd=0, WBsrc=01, MemOut=16'hFFFF -> regWr never asserts, wb_done still pulses. Repeat with WBsrc=11 and rd=4 -> no write.
- Overrun and set-wins:
  - enable_WB again during WRITE -> wb_overrun=1, held; the write in progress is unchanged.
  - issue_valid with issue_rd=3 in the same cycle as DONE for R3 -> busy[3] remains 1.
- With WB_BYPASS_EN, ALUout=16'h00A5, rd=6 -> in WRITE, fwd_valid=1, fwd_rd=6, fwd_data=16'h00A5. Without the macro, fwd_* stays 0 for the same stimulus.
